dmc_channel: RTL and testbench
==============================

// Module: dmc_channel
// PURPOSE
//  APU delta-modulation channel: fetches 1-bit delta samples from CPU memory via a req/ack
//  port, plays them into a 7-bit level for the mixer's dmc input, and raises a sample-end IRQ.
//  Sits inside apu beside pulse/triangle/noise; driven by the $4010-$4013/$4015 register strobes.
// PARAMETERS
//  SAMPLE_BASE  16'hC000  start address origin; start = SAMPLE_BASE + addr_data*64
//  WRAP_ADDR    16'h8000  address that follows 16'hFFFF during fetch increment
// PORTS
//  clk            in   1   system clock
//  rst_l          in   1   asynchronous active-low reset
//  cpu_clk_en     in   1   one-cycle CPU tick strobe; the timer advances only on it
//  ctrl_load      in   1   $4010 write strobe; ctrl_data[7]=irq_en, [6]=loop, [3:0]=rate index
//  ctrl_data      in   8   $4010 data
//  direct_load    in   1   $4011 write strobe; level <= direct_data[6:0]
//  direct_data    in   8   $4011 data
//  addr_load      in   1   $4012 write strobe
//  addr_data      in   8   $4012 data
//  len_load       in   1   $4013 write strobe; length = len_data*16 + 1 bytes
//  len_data       in   8   $4013 data
//  status_load    in   1   $4015 write strobe
//  enable         in   1   $4015 bit 4 value, sampled on status_load
//  mem_req        out  1   fetch request, held high until mem_ack
//  mem_addr       out  16  fetch address, stable while mem_req high
//  mem_ack        in   1   one-cycle pulse, data valid; may arrive on any clk edge
//  mem_data       in   8   fetched byte
//  length_non_zero out 1   bytes_remaining != 0 (to $4015 read)
//  irq_l          out  1   active-low sample-end interrupt
//  out            out  7   DAC level to mixer
// BEHAVIOUR
//  Reset: out=0, irq_l=1, mem_req=0, mem_addr=SAMPLE_BASE, bytes_rem=0, buffer empty,
//   silence=1, bits_rem=8, shift=0, timer=rate[0]-1; registers irq_en/loop/rate/addr/len = 0.
//  Timer (only on cpu_clk_en): if timer==0 reload rate[idx]-1 and tick output unit, else timer-1.
//   NTSC rate table (CPU cycles): 428,380,340,320,286,254,226,214,190,160,142,128,106,84,72,54.
//  Output unit tick: if !silence: shift[0]=1 and out<=125 -> out+=2; shift[0]=0 and out>=2 ->
//   out-=2; else unchanged (clamp 0..127). Then shift>>=1, bits_rem-=1. When bits_rem reaches 0:
//   bits_rem=8; buffer full -> shift<=buffer, silence=0, buffer empty; else silence=1.
//  direct_load: out<=direct_data[6:0] next clk; wins over a same-cycle output delta.
//  Reader FSM IDLE/REQ: IDLE->REQ when buffer empty && bytes_rem!=0 (mem_req rises next clk).
//   REQ: hold mem_req/mem_addr until mem_ack; on ack: buffer<=mem_data, mem_addr += 1
//   (16'hFFFF -> WRAP_ADDR), bytes_rem-=1, ->IDLE. At most one outstanding request.
//   If bytes_rem becomes 0: loop=1 -> mem_addr=start, bytes_rem=length; else irq_en=1 -> irq_l=0.
//  Buffer is refilled earliest one clk after emptying; ack and shift-load same cycle is legal.
//  status_load: always clears IRQ. enable=0 -> bytes_rem=0 (in-flight request still completes
//   and fills buffer, no IRQ). enable=1 and bytes_rem==0 -> mem_addr=start, bytes_rem=length.
//   enable=1 and bytes_rem!=0 -> no effect on fetch.
//  ctrl_load with ctrl_data[7]=0 clears IRQ; rate change takes effect at next timer reload.
//  mem_ack + status_load(enable=0) same cycle: ack processed, then bytes_rem forced 0; no IRQ.
//  mem_ack with bytes_rem->0 + status_load same cycle: status clear wins, irq_l stays 1.
//  mem_ack while mem_req low: ignored.
// CONFIGURATION
//  DMC_PAL_RATES_EN defined: rate table is PAL (398,354,316,298,276,236,210,198,176,148,132,118,
//   98,78,66,50). Undefined: NTSC table above. No other behaviour changes.
// TESTING
//  Reset mid-fetch (mem_req=1) -> all outputs at reset values next clk, later ack ignored.
//  direct_load data 8'hC0 -> out=7'h40 next clk; no mem_req.
//  addr=8'h01,len=0,rate=15,enable -> mem_req, mem_addr=16'hC040; ack 8'hFF -> out rises by 2
//   every 54 cpu ticks, 8 times, then silence holds level.
//  irq_en=1,loop=0,len=0 -> after single ack irq_l=0, length_non_zero=0; status_load -> irq_l=1.
//  loop=1,addr=8'hFF,len=8'h04 -> 65 fetches 16'hFFC0..16'hFFFF then 16'h8000; fetch 66 at 16'hFFC0.
//  Clamp: direct 126, byte 8'hFF -> out stays 126; direct 1, byte 8'h00 -> out stays 1.

Source files
------------

// File: rtl/dmc_channel.sv
// dmc_channel: APU delta-modulation channel (sample fetch, 1-bit delta DAC level, sample-end IRQ).
// Define DMC_PAL_RATES_EN to select the PAL timer period table instead of the NTSC one.
module dmc_channel #(
  parameter logic [15:0] SAMPLE_BASE = 16'hC000,
  parameter logic [15:0] WRAP_ADDR   = 16'h8000
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cpu_clk_en,
  input  logic        ctrl_load,
  input  logic [7:0]  ctrl_data,
  input  logic        direct_load,
  input  logic [7:0]  direct_data,
  input  logic        addr_load,
  input  logic [7:0]  addr_data,
  input  logic        len_load,
  input  logic [7:0]  len_data,
  input  logic        status_load,
  input  logic        enable,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        length_non_zero,
  output logic        irq_l,
  output logic [6:0]  out
);

  localparam int unsigned TIMER_W = 9;
  localparam int unsigned BYTES_W = 12;
  localparam int unsigned OUT_W   = 7;

  typedef enum logic {ST_IDLE, ST_REQ} rd_state_e;

  // Timer period in CPU cycles for each rate index.
  function automatic logic [TIMER_W-1:0] rate_period(input logic [3:0] idx);
    logic [TIMER_W-1:0] p;
    p = '0;
    case (idx)
`ifdef DMC_PAL_RATES_EN
      4'd0:  p = 9'd398;  4'd1:  p = 9'd354;  4'd2:  p = 9'd316;  4'd3:  p = 9'd298;
      4'd4:  p = 9'd276;  4'd5:  p = 9'd236;  4'd6:  p = 9'd210;  4'd7:  p = 9'd198;
      4'd8:  p = 9'd176;  4'd9:  p = 9'd148;  4'd10: p = 9'd132;  4'd11: p = 9'd118;
      4'd12: p = 9'd98;   4'd13: p = 9'd78;   4'd14: p = 9'd66;   4'd15: p = 9'd50;
`else
      4'd0:  p = 9'd428;  4'd1:  p = 9'd380;  4'd2:  p = 9'd340;  4'd3:  p = 9'd320;
      4'd4:  p = 9'd286;  4'd5:  p = 9'd254;  4'd6:  p = 9'd226;  4'd7:  p = 9'd214;
      4'd8:  p = 9'd190;  4'd9:  p = 9'd160;  4'd10: p = 9'd142;  4'd11: p = 9'd128;
      4'd12: p = 9'd106;  4'd13: p = 9'd84;   4'd14: p = 9'd72;   4'd15: p = 9'd54;
`endif
      default: p = '0;
    endcase
    return p;
  endfunction

  rd_state_e            state_q, state_d;
  logic                 irq_en_q, irq_en_d;
  logic                 loop_q, loop_d;
  logic [3:0]           rate_q, rate_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic [7:0]           shift_q, shift_d;
  logic [3:0]           bits_q, bits_d;
  logic                 silence_q, silence_d;
  logic [7:0]           buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic [BYTES_W-1:0]   bytes_q, bytes_d;
  logic                 mem_req_q, mem_req_d;
  logic [15:0]          mem_addr_q, mem_addr_d;
  logic                 irq_l_q, irq_l_d;
  logic                 lnz_q, lnz_d;

  logic [15:0]          start_addr_c;
  logic [BYTES_W-1:0]   length_c;
  logic                 unused_bits;

  assign start_addr_c = SAMPLE_BASE + {2'b00, addr_q, 6'b000000};
  assign length_c     = {len_q, 4'b0000} + BYTES_W'(1);
  assign unused_bits  = ^{direct_data[7], ctrl_data[5:4]};

  always_comb begin
    state_d    = state_q;
    irq_en_d   = irq_en_q;
    loop_d     = loop_q;
    rate_d     = rate_q;
    addr_d     = addr_q;
    len_d      = len_q;
    timer_d    = timer_q;
    out_d      = out_q;
    shift_d    = shift_q;
    bits_d     = bits_q;
    silence_d  = silence_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    bytes_d    = bytes_q;
    mem_addr_d = mem_addr_q;
    irq_l_d    = irq_l_q;

    if (ctrl_load) begin
      irq_en_d = ctrl_data[7];
      loop_d   = ctrl_data[6];
      rate_d   = ctrl_data[3:0];
    end
    if (addr_load) addr_d = addr_data;
    if (len_load)  len_d  = len_data;

    // Timer and output unit: one delta bit per timer expiry.
    if (cpu_clk_en) begin
      if (timer_q == '0) begin
        timer_d = rate_period(rate_q) - TIMER_W'(1);
        if (!silence_q) begin
          if (shift_q[0] && out_q <= OUT_W'(125))      out_d = out_q + OUT_W'(2);
          else if (!shift_q[0] && out_q >= OUT_W'(2))  out_d = out_q - OUT_W'(2);
        end
        shift_d = shift_q >> 1;
        if (bits_q == 4'd1) begin
          bits_d = 4'd8;
          if (buf_full_q) begin
            shift_d    = buf_q;
            silence_d  = 1'b0;
            buf_full_d = 1'b0;
          end else begin
            silence_d = 1'b1;
          end
        end else begin
          bits_d = bits_q - 4'd1;
        end
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end

    // Reader: one outstanding fetch, issued only into an empty buffer.
    case (state_q)
      ST_IDLE: if (!buf_full_q && bytes_q != '0) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_ack) begin
          state_d    = ST_IDLE;
          buf_d      = mem_data;
          buf_full_d = 1'b1;
          mem_addr_d = (mem_addr_q == 16'hFFFF) ? WRAP_ADDR : mem_addr_q + 16'd1;
          // bytes_q is already zero when the channel was disabled mid-fetch.
          if (bytes_q != '0) begin
            bytes_d = bytes_q - BYTES_W'(1);
            if (bytes_q == BYTES_W'(1)) begin
              if (loop_q) begin
                mem_addr_d = start_addr_c;
                bytes_d    = length_c;
              end else if (irq_en_q) begin
                irq_l_d = 1'b0;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ctrl_load && !ctrl_data[7]) irq_l_d = 1'b1;

    if (status_load) begin
      irq_l_d = 1'b1;
      if (!enable) begin
        bytes_d = '0;
      end else if (bytes_d == '0) begin
        mem_addr_d = start_addr_c;
        bytes_d    = length_c;
      end
    end

    if (direct_load) out_d = direct_data[6:0];

    mem_req_d = (state_d == ST_REQ);
    lnz_d     = (bytes_d != '0);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= ST_IDLE;
      irq_en_q   <= 1'b0;
      loop_q     <= 1'b0;
      rate_q     <= 4'd0;
      addr_q     <= 8'd0;
      len_q      <= 8'd0;
      timer_q    <= rate_period(4'd0) - TIMER_W'(1);
      out_q      <= '0;
      shift_q    <= 8'd0;
      bits_q     <= 4'd8;
      silence_q  <= 1'b1;
      buf_q      <= 8'd0;
      buf_full_q <= 1'b0;
      bytes_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= SAMPLE_BASE;
      irq_l_q    <= 1'b1;
      lnz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_en_q   <= irq_en_d;
      loop_q     <= loop_d;
      rate_q     <= rate_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      out_q      <= out_d;
      shift_q    <= shift_d;
      bits_q     <= bits_d;
      silence_q  <= silence_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      bytes_q    <= bytes_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      irq_l_q    <= irq_l_d;
      lnz_q      <= lnz_d;
    end
  end

  assign mem_req         = mem_req_q;
  assign mem_addr        = mem_addr_q;
  assign length_non_zero = lnz_q;
  assign irq_l           = irq_l_q;
  assign out             = out_q;

endmodule

// File: tb/tb_dmc_channel.sv
// tb_dmc_channel: randomized self-checking bench for dmc_channel against a sample-stream level model.
// Honours DMC_PAL_RATES_EN for the expected timer periods.
module tb_dmc_channel;

`ifdef DMC_PAL_RATES_EN
  localparam int RATE0  = 398;
  localparam int RATE15 = 50;
`else
  localparam int RATE0  = 428;
  localparam int RATE15 = 54;
`endif
  localparam int NCPU = RATE0 + 23 * RATE15;

  logic        clk, rst_l, cpu_clk_en;
  logic        ctrl_load, direct_load, addr_load, len_load, status_load, enable;
  logic [7:0]  ctrl_data, direct_data, addr_data, len_data;
  logic        mem_req, mem_ack, length_non_zero, irq_l;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [6:0]  out;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  seed;
  bit          resp_en, resp_force;
  logic [7:0]  force_data;
  int          resp_wait;
  logic [15:0] fetch_log[$];
  logic [7:0]  exp_bytes[$];

  dmc_channel dut (
    .clk(clk), .rst_l(rst_l), .cpu_clk_en(cpu_clk_en),
    .ctrl_load(ctrl_load), .ctrl_data(ctrl_data),
    .direct_load(direct_load), .direct_data(direct_data),
    .addr_load(addr_load), .addr_data(addr_data),
    .len_load(len_load), .len_data(len_data),
    .status_load(status_load), .enable(enable),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .length_non_zero(length_non_zero), .irq_l(irq_l), .out(out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Contents of CPU memory as seen by the channel.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [15:0] h;
    h = a * 16'd40503;
    return h[15:8] ^ h[7:0] ^ seed;
  endfunction

  // Output-unit ticks completed after c CPU cycles since reset (rate index 15 after the first).
  function automatic int ticks(input int c);
    return (c < RATE0) ? 0 : 1 + (c - RATE0) / RATE15;
  endfunction

  // Level after k ticks: first 8 ticks silent, then one queued byte per 8 ticks, LSB first.
  function automatic int model_level(input int k, input int l0);
    int lv;
    lv = l0;
    for (int s = 0; s < k; s++) begin
      int g;
      g = s / 8;
      if (g >= 1 && g - 1 < exp_bytes.size()) begin
        logic [7:0] b;
        b = exp_bytes[g-1];
        if (b[s % 8]) begin
          if (lv <= 125) lv += 2;
        end else if (lv >= 2) begin
          lv -= 2;
        end
      end
    end
    return lv;
  endfunction

  // Advance one clock; clear strobes and run the memory responder on the falling edge.
  task automatic cycle();
    @(negedge clk);
    ctrl_load = 0; direct_load = 0; addr_load = 0; len_load = 0; status_load = 0;
    mem_ack = 0; cpu_clk_en = 0;
    if (resp_en && mem_req) begin
      if (resp_wait == 0) begin
        mem_ack  = 1;
        mem_data = resp_force ? force_data : mem_byte(mem_addr);
        fetch_log.push_back(mem_addr);
        resp_wait = int'($urandom_range(0, 3));
      end else begin
        resp_wait--;
      end
    end
  endtask

  task automatic wr_reg(input int r, input logic [7:0] d);
    cycle();
    case (r)
      0: begin ctrl_load = 1;   ctrl_data = d;   end
      1: begin direct_load = 1; direct_data = d; end
      2: begin addr_load = 1;   addr_data = d;   end
      3: begin len_load = 1;    len_data = d;    end
      default: begin status_load = 1; enable = d[4]; end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 0; resp_en = 0; resp_force = 0; resp_wait = 0;
    ctrl_load = 0; direct_load = 0; addr_load = 0; len_load = 0; status_load = 0;
    enable = 0; mem_ack = 0; cpu_clk_en = 0;
    repeat (2) @(negedge clk);
    rst_l = 1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (mem_req) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic setup_manual(input logic [7:0] ctl, input logic [7:0] len, output logic [15:0] start);
    logic [7:0] a;
    bit ok;
    do_reset();
    a = 8'($urandom);
    start = 16'hC000 + {2'b00, a, 6'b000000};
    wr_reg(0, ctl); wr_reg(2, a); wr_reg(3, len); wr_reg(4, 8'h10);
    wait_req(ok);
    n_chk++; if (!ok || mem_addr !== start) $display("FAIL req_addr: req %0b addr %h exp %h", ok, mem_addr, start); else n_pass++;
  endtask

  task automatic test_reset();
    logic [15:0] st;
    do_reset();
    cycle();
    n_chk++; if (out !== 7'd0) $display("FAIL reset_out: got %0d exp 0", out); else n_pass++;
    n_chk++; if (irq_l !== 1'b1) $display("FAIL reset_irq: got %b exp 1", irq_l); else n_pass++;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b exp 0", mem_req); else n_pass++;
    n_chk++; if (mem_addr !== 16'hC000) $display("FAIL reset_addr: got %h exp c000", mem_addr); else n_pass++;
    n_chk++; if (length_non_zero !== 1'b0) $display("FAIL reset_lnz: got %b exp 0", length_non_zero); else n_pass++;
    // Reset while a fetch is outstanding, then a stray ack.
    setup_manual(8'h8F, 8'h02, st);
    rst_l = 0;
    @(posedge clk); #1;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL midrst_req: got %b exp 0", mem_req); else n_pass++;
    n_chk++; if (mem_addr !== 16'hC000) $display("FAIL midrst_addr: got %h exp c000", mem_addr); else n_pass++;
    n_chk++; if (length_non_zero !== 1'b0) $display("FAIL midrst_lnz: got %b exp 0", length_non_zero); else n_pass++;
    @(negedge clk); rst_l = 1;
    cycle(); mem_ack = 1; mem_data = 8'hFF;
    cycle(); cycle();
    n_chk++; if (mem_req !== 1'b0 || mem_addr !== 16'hC000) $display("FAIL midrst_ack: req %b addr %h exp 0 c000", mem_req, mem_addr); else n_pass++;
    n_chk++; if (irq_l !== 1'b1 || out !== 7'd0) $display("FAIL midrst_state: irq %b out %0d exp 1 0", irq_l, out); else n_pass++;
  endtask

  task automatic test_direct();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      d = (i == 0) ? 8'hC0 : 8'($urandom);
      wr_reg(1, d);
      cycle();
      n_chk++; if (out !== d[6:0]) $display("FAIL direct_out: got %h exp %h", out, d[6:0]); else n_pass++;
      n_chk++; if (mem_req !== 1'b0) $display("FAIL direct_req: got %b exp 0", mem_req); else n_pass++;
    end
  endtask

  task automatic test_play();
    logic [7:0] a;
    logic [15:0] start;
    int l0, base, exp;
    bit ie;
    do_reset();
    resp_en = 1;
    a = 8'($urandom);
    l0 = int'($urandom_range(0, 127));
    ie = 1'($urandom_range(0, 1));
    start = 16'hC000 + {2'b00, a, 6'b000000};
    exp_bytes.delete();
    exp_bytes.push_back(mem_byte(start));
    base = fetch_log.size();
    wr_reg(0, {ie, 3'b000, 4'hF}); wr_reg(1, 8'(l0)); wr_reg(2, a); wr_reg(3, 8'h00); wr_reg(4, 8'h10);
    for (int c = 1; c <= NCPU; c++) begin
      repeat (int'($urandom_range(0, 2))) cycle();
      cycle(); cpu_clk_en = 1;
      cycle();
      exp = model_level(ticks(c), l0);
      n_chk++; if (out !== 7'(exp)) $display("FAIL play_out c=%0d: got %0d exp %0d", c, out, exp); else n_pass++;
    end
    n_chk++; if (fetch_log.size() - base != 1) $display("FAIL play_nfetch: got %0d exp 1", fetch_log.size() - base); else n_pass++;
    if (fetch_log.size() > base) begin
      n_chk++; if (fetch_log[base] !== start) $display("FAIL play_faddr: got %h exp %h", fetch_log[base], start); else n_pass++;
    end
    n_chk++; if (mem_addr !== start + 16'd1) $display("FAIL play_addr: got %h exp %h", mem_addr, start + 16'd1); else n_pass++;
    n_chk++; if (length_non_zero !== 1'b0) $display("FAIL play_lnz: got %b exp 0", length_non_zero); else n_pass++;
    n_chk++; if (irq_l !== !ie) $display("FAIL play_irq: got %b exp %b", irq_l, !ie); else n_pass++;
  endtask

  task automatic test_irq();
    logic [15:0] st;
    // Sample end raises IRQ; status write clears it.
    setup_manual(8'h8F, 8'h00, st);
    cycle(); mem_ack = 1; mem_data = 8'($urandom);
    cycle();
    n_chk++; if (irq_l !== 1'b0) $display("FAIL irq_set: got %b exp 0", irq_l); else n_pass++;
    n_chk++; if (length_non_zero !== 1'b0) $display("FAIL irq_lnz: got %b exp 0", length_non_zero); else n_pass++;
    n_chk++; if (mem_req !== 1'b0 || mem_addr !== st + 16'd1) $display("FAIL irq_addr: req %b addr %h exp 0 %h", mem_req, mem_addr, st + 16'd1); else n_pass++;
    wr_reg(4, 8'h00); cycle();
    n_chk++; if (irq_l !== 1'b1) $display("FAIL irq_status_clr: got %b exp 1", irq_l); else n_pass++;
    // ctrl write with irq_en=0 clears it.
    setup_manual(8'h8F, 8'h00, st);
    cycle(); mem_ack = 1;
    cycle();
    n_chk++; if (irq_l !== 1'b0) $display("FAIL irq_set2: got %b exp 0", irq_l); else n_pass++;
    wr_reg(0, 8'h0F); cycle();
    n_chk++; if (irq_l !== 1'b1) $display("FAIL irq_ctrl_clr: got %b exp 1", irq_l); else n_pass++;
    // Last ack together with a disabling status write: no IRQ.
    setup_manual(8'h8F, 8'h00, st);
    cycle(); mem_ack = 1; status_load = 1; enable = 0;
    cycle();
    n_chk++; if (irq_l !== 1'b1 || length_non_zero !== 1'b0) $display("FAIL irq_ack_dis: irq %b lnz %b exp 1 0", irq_l, length_non_zero); else n_pass++;
    // Last ack together with an enabling status write: the clear wins.
    setup_manual(8'h8F, 8'h00, st);
    cycle(); mem_ack = 1; status_load = 1; enable = 1;
    cycle();
    n_chk++; if (irq_l !== 1'b1) $display("FAIL irq_ack_en: got %b exp 1", irq_l); else n_pass++;
    // Disable mid-fetch: request completes, no IRQ.
    setup_manual(8'h8F, 8'h01, st);
    n_chk++; if (length_non_zero !== 1'b1) $display("FAIL inflight_lnz1: got %b exp 1", length_non_zero); else n_pass++;
    wr_reg(4, 8'h00); cycle();
    n_chk++; if (mem_req !== 1'b1 || length_non_zero !== 1'b0) $display("FAIL inflight_dis: req %b lnz %b exp 1 0", mem_req, length_non_zero); else n_pass++;
    cycle(); mem_ack = 1;
    cycle(); cycle();
    n_chk++; if (mem_req !== 1'b0 || irq_l !== 1'b1 || mem_addr !== st + 16'd1) $display("FAIL inflight_done: req %b irq %b addr %h exp 0 1 %h", mem_req, irq_l, mem_addr, st + 16'd1); else n_pass++;
    // Ack with no request outstanding is ignored.
    do_reset();
    wr_reg(2, 8'($urandom)); wr_reg(0, 8'h8F);
    cycle(); mem_ack = 1; mem_data = 8'h55;
    cycle(); cycle();
    n_chk++; if (mem_req !== 1'b0 || mem_addr !== 16'hC000 || length_non_zero !== 1'b0) $display("FAIL stray_ack: req %b addr %h lnz %b exp 0 c000 0", mem_req, mem_addr, length_non_zero); else n_pass++;
  endtask

  task automatic test_clamp(input logic [6:0] d, input logic [7:0] b);
    int base;
    do_reset();
    resp_en = 1; resp_force = 1; force_data = b;
    base = fetch_log.size();
    wr_reg(0, 8'h0F); wr_reg(1, {1'b0, d}); wr_reg(2, 8'($urandom)); wr_reg(3, 8'h00); wr_reg(4, 8'h10);
    for (int c = 0; c < NCPU; c++) begin
      cycle();
      n_chk++; if (out !== d) $display("FAIL clamp_out c=%0d: got %0d exp %0d", c, out, d); else n_pass++;
      cpu_clk_en = 1;
    end
    n_chk++; if (fetch_log.size() - base != 1) $display("FAIL clamp_nfetch: got %0d exp 1", fetch_log.size() - base); else n_pass++;
  endtask

  task automatic test_loop();
    int base;
    logic [15:0] ea;
    do_reset();
    resp_en = 1;
    base = fetch_log.size();
    wr_reg(0, 8'h4F); wr_reg(2, 8'hFF); wr_reg(3, 8'h04); wr_reg(4, 8'h10);
    for (int c = 0; c < 40000; c++) begin
      cycle();
      if (fetch_log.size() - base >= 66) break;
      cpu_clk_en = 1;
    end
    n_chk++; if (fetch_log.size() - base < 66) $display("FAIL loop_nfetch: got %0d exp 66", fetch_log.size() - base); else n_pass++;
    for (int i = 0; i < 66; i++) begin
      if (base + i < fetch_log.size()) begin
        ea = (i < 64) ? 16'hFFC0 + 16'(i) : ((i == 64) ? 16'h8000 : 16'hFFC0);
        n_chk++; if (fetch_log[base+i] !== ea) $display("FAIL loop_addr[%0d]: got %h exp %h", i, fetch_log[base+i], ea); else n_pass++;
      end
    end
    n_chk++; if (length_non_zero !== 1'b1 || irq_l !== 1'b1) $display("FAIL loop_state: lnz %b irq %b exp 1 1", length_non_zero, irq_l); else n_pass++;
  endtask

  initial begin
    rst_l = 0; cpu_clk_en = 0; enable = 0; mem_ack = 0; mem_data = 0;
    ctrl_load = 0; direct_load = 0; addr_load = 0; len_load = 0; status_load = 0;
    ctrl_data = 0; direct_data = 0; addr_data = 0; len_data = 0;
    resp_en = 0; resp_force = 0; force_data = 0; resp_wait = 0;
    seed = 8'($urandom);
    test_reset();
    test_direct();
    test_play();
    test_play();
    test_irq();
    test_clamp(7'd126, 8'hFF);
    test_clamp(7'd1, 8'h00);
    test_loop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
